// File: rtl/soc_pkg.sv
// Shared SoC register constants: timer register addresses and CTRL bit positions.
package soc_pkg;

  typedef enum logic [1:0] {
    ADDR_CTRL   = 2'd0,
    ADDR_STATUS = 2'd1,
    ADDR_RELOAD = 2'd2,
    ADDR_COUNT  = 2'd3
  } reg_addr_e;

  localparam int unsigned CTRL_EN   = 0;
  localparam int unsigned CTRL_AUTO = 1;
  localparam int unsigned CTRL_IE   = 2;

  localparam int unsigned STATUS_EXP = 0;

endpackage

// File: rtl/ce_timer_if.sv
// Register bus between a bus master and the ce_timer slave, plus the interrupt line.
interface ce_timer_if #(
  parameter int unsigned WIDTH = 16
);
  logic [1:0]       addr;
  logic             we;
  logic             re;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] rdata;
  logic             irq;

  modport master (output addr, output we, output re, output wdata, input rdata, input irq);
  modport slave  (input addr, input we, input re, input wdata, output rdata, output irq);
endinterface

// File: rtl/ce_timer.sv
// Down-counting timer clocked by an external clock-enable strobe, with a
// four-register slave port, sticky expiry flag and level interrupt.
module ce_timer
  import soc_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_ce,
  ce_timer_if.slave   bus
);

  logic             en, auto_mode, ie, exp_flag;
  logic [WIDTH-1:0] reload, count;

  logic             en_n, auto_n, ie_n, exp_n;
  logic [WIDTH-1:0] reload_n, count_n, rdata_sel;

  logic ctrl_wr, status_wr, reload_wr, count_wr;
  logic tick, expire, oneshot_stop, arm;

  always_comb begin
    ctrl_wr   = bus.we && (reg_addr_e'(bus.addr) == ADDR_CTRL);
    status_wr = bus.we && (reg_addr_e'(bus.addr) == ADDR_STATUS);
    reload_wr = bus.we && (reg_addr_e'(bus.addr) == ADDR_RELOAD);
    count_wr  = bus.we && (reg_addr_e'(bus.addr) == ADDR_COUNT);

    tick         = en && i_ce;
    expire       = tick && (count == '0);
    oneshot_stop = expire && !auto_mode;
    // EN that is about to self-clear counts as 0 for arming purposes.
    arm          = ctrl_wr && bus.wdata[CTRL_EN] && (!en || oneshot_stop);

    en_n     = en;
    auto_n   = auto_mode;
    ie_n     = ie;
    exp_n    = exp_flag;
    reload_n = reload;
    count_n  = count;

    if (oneshot_stop) en_n = 1'b0;
    if (ctrl_wr) begin
      en_n   = bus.wdata[CTRL_EN];
      auto_n = bus.wdata[CTRL_AUTO];
      ie_n   = bus.wdata[CTRL_IE];
    end

    if (status_wr && bus.wdata[STATUS_EXP]) exp_n = 1'b0;
    if (expire) exp_n = 1'b1;

    if (reload_wr) reload_n = bus.wdata;

    if (tick) begin
      if (count != '0) count_n = count - 1'b1;
      else if (auto_mode) count_n = reload;
    end
    if (arm) count_n = reload;
    if (count_wr) count_n = bus.wdata;

    rdata_sel = '0;
    case (reg_addr_e'(bus.addr))
      ADDR_CTRL: begin
        rdata_sel[CTRL_EN]   = en;
        rdata_sel[CTRL_AUTO] = auto_mode;
        rdata_sel[CTRL_IE]   = ie;
      end
      ADDR_STATUS: rdata_sel[STATUS_EXP] = exp_flag;
      ADDR_RELOAD: rdata_sel = reload;
      ADDR_COUNT:  rdata_sel = count;
      default:     rdata_sel = '0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      en        <= 1'b0;
      auto_mode <= 1'b0;
      ie        <= 1'b0;
      exp_flag  <= 1'b0;
      reload    <= '0;
      count     <= '0;
      bus.rdata <= '0;
    end else begin
      en        <= en_n;
      auto_mode <= auto_n;
      ie        <= ie_n;
      exp_flag  <= exp_n;
      reload    <= reload_n;
      count     <= count_n;
      if (bus.re) bus.rdata <= rdata_sel;
    end
  end

  assign bus.irq = ie && exp_flag;

endmodule
